// File: rtl/tbman.sv
// Testbench manager: ID, 64-bit cycle counter with high-word snapshot,
// pass/fail reporting, console byte FIFO and a scratch register.
module tbman #(
    parameter logic [31:0] ID_VALUE   = 32'h7B3A_0001,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_tbman_n,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data_tbman,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        test_done,
    output logic        test_pass
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        REG_ID       = 3'd0,
        REG_CYCLE_LO = 3'd1,
        REG_CYCLE_HI = 3'd2,
        REG_RESULT   = 3'd3,
        REG_PUTC     = 3'd4,
        REG_STATUS   = 3'd5,
        REG_SCRATCH  = 3'd6,
        REG_RSVD     = 3'd7
    } reg_sel_t;

    reg_sel_t       sel;
    logic           rd_en;
    logic           wr_en;
    logic [63:0]    cycle_cnt;
    logic [31:0]    hi_shadow;
    logic [31:0]    scratch;
    logic           overflow;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;
    logic           pop;
    logic           putc_wr;
    logic           push;
    logic           ov_event;
    logic [31:0]    rdata_next;
    logic           unused_addr;

    assign sel         = reg_sel_t'(addr[4:2]);
    assign unused_addr = ^{addr[7:5], addr[1:0]};
    assign rd_en       = ~cs_tbman_n & ~we;
    assign wr_en       = ~cs_tbman_n & we;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign tx_valid = ~empty;
    assign tx_data  = mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    assign putc_wr  = wr_en && (sel == REG_PUTC);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push     = putc_wr && (!full || pop);
    assign ov_event = putc_wr && full && !pop;

    always_comb begin
        rdata_next = '0;
        case (sel)
            REG_ID:       rdata_next = ID_VALUE;
            REG_CYCLE_LO: rdata_next = cycle_cnt[31:0];
            REG_CYCLE_HI: rdata_next = hi_shadow;
            REG_RESULT:   rdata_next = {30'd0, test_done, test_pass};
            REG_STATUS:   rdata_next = {23'd0, overflow, full, empty, 6'(count)};
            REG_SCRATCH:  rdata_next = scratch;
            default:      rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt       <= '0;
            hi_shadow       <= '0;
            read_data_tbman <= '0;
            test_done       <= 1'b0;
            test_pass       <= 1'b0;
            scratch         <= '0;
            overflow        <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (rd_en) begin
                read_data_tbman <= rdata_next;
                if (sel == REG_CYCLE_LO)
                    hi_shadow <= cycle_cnt[63:32];
            end
            if (wr_en && (sel == REG_RESULT) && !test_done) begin
                test_done <= 1'b1;
                test_pass <= write_data[0];
            end
            if (wr_en && (sel == REG_SCRATCH))
                scratch <= write_data;
            if (ov_event)
                overflow <= 1'b1;
            else if (rd_en && (sel == REG_STATUS))
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= write_data[7:0];
    end

endmodule
